// File: rtl/rmm_pkg.sv
// ------------------------------------------------------------------
// rmm_pkg : shared types and helpers for the radix-4 multiplier slice
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package rmm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } rmm_state_e;

    localparam int RMM_W_DEFAULT = 8;

    // Bit position of the partial product of digit pair (i, j).
    function automatic int digit_shift(input int i, input int j);
        return 2 * (i + j);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rmme2.sv
// ------------------------------------------------------------------
// rmme2 : 2-bit x 2-bit partial-product cell with exponent-mode flags
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module rmme2 (
    input  logic [1:0] A,
    input  logic [1:0] B,
    output logic [3:0] PP,
    output logic       EMax,
    output logic       OE1,
    output logic       OE2
);

    assign PP   = {2'b00, A} * {2'b00, B};
    assign OE1  = |A;
    assign OE2  = |B;
    assign EMax = (A > B);

endmodule

`default_nettype wire

// File: rtl/rmm_seq_ctrl.sv
// ------------------------------------------------------------------
// rmm_seq_ctrl : iterative W x W unsigned multiplier over one rmme2 cell
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module rmm_seq_ctrl
    import rmm_pkg::*;
#(
    parameter int W = RMM_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_p,
    output logic           busy
);

    localparam int  N    = W / 2;
    localparam int  NN   = N * N;
    localparam int  KW   = $clog2(NN);
    localparam int  IW   = $clog2(N);
    localparam bit  POW2 = ((N & (N - 1)) == 0);

    rmm_state_e       state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [IW-1:0]    w_i, w_j;
    logic             w_last, w_accept, w_step;
    logic [1:0]       w_a_dig, w_b_dig;
    logic [3:0]       w_pp;
    logic [2*W-1:0]   w_addend;
    logic             w_unused_emax, w_unused_oe1, w_unused_oe2;

    assign w_accept = (state_q == IDLE) && in_valid;
    assign w_step   = (state_q == BUSY);

    // Power-of-two digit counts let i/j be plain fields of one counter.
    generate
        if (POW2) begin : g_split_k
            logic [KW-1:0] k_q, k_d;

            always_comb begin
                k_d = k_q;
                if (w_accept)    k_d = '0;
                else if (w_step) k_d = k_q + KW'(1);
            end

            always_ff @(posedge clk) begin
                if (!rst_n) k_q <= '0;
                else        k_q <= k_d;
            end

            assign w_i    = k_q[IW-1:0];
            assign w_j    = k_q[KW-1:IW];
            assign w_last = (k_q == KW'(NN - 1));
        end else begin : g_ij_cnt
            logic [IW-1:0] i_q, i_d, j_q, j_d;

            always_comb begin
                i_d = i_q;
                j_d = j_q;
                if (w_accept) begin
                    i_d = '0;
                    j_d = '0;
                end else if (w_step) begin
                    if (i_q == IW'(N - 1)) begin
                        i_d = '0;
                        j_d = j_q + IW'(1);
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    i_q <= '0;
                    j_q <= '0;
                end else begin
                    i_q <= i_d;
                    j_q <= j_d;
                end
            end

            assign w_i    = i_q;
            assign w_j    = j_q;
            assign w_last = (i_q == IW'(N - 1)) && (j_q == IW'(N - 1));
        end
    endgenerate

    assign w_a_dig = 2'(a_q >> {w_i, 1'b0});
    assign w_b_dig = 2'(b_q >> {w_j, 1'b0});

    rmme2 u_cell (
        .A    (w_a_dig),
        .B    (w_b_dig),
        .PP   (w_pp),
        .EMax (w_unused_emax),
        .OE1  (w_unused_oe1),
        .OE2  (w_unused_oe2)
    );

    assign w_addend = {{(2*W-4){1'b0}}, w_pp} << digit_shift(int'(w_i), int'(w_j));

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (w_accept) begin
            a_d   = in_a;
            b_d   = in_b;
            acc_d = '0;
        end else if (w_step) begin
            acc_d = acc_q + w_addend;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (w_last)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == BUSY) || (state_q == DONE);
    end

    assign out_p = acc_q;

endmodule

`default_nettype wire
